// File: rtl/qu_pkg.sv
// -----------------------------------------------------------------------------
// qu_pkg -- shared types and constants for the qu core front end.
//
// Contents:
//   QU_PC_WIDTH, QU_PC_RESET_VAL : byte-address width and reset fetch address
//   QU_FETCH_DEPTH               : instruction buffer entry count
//   instr_t                      : 32-bit instruction word
//   fetch_state_t                : fetch controller FSM states (BOOT/RUN/HALT)
//   get_encoding_syscall_instr   : builds a SYSTEM-opcode call/break word
//   INSTR_EBREAK                 : EBREAK encoding (0x00100073)
// -----------------------------------------------------------------------------
package qu_pkg;

    localparam int                     QU_PC_WIDTH     = 12;
    localparam logic [QU_PC_WIDTH-1:0] QU_PC_RESET_VAL = 12'h000;
    localparam int                     QU_FETCH_DEPTH  = 2;

    typedef logic [31:0] instr_t;

    localparam logic [6:0] OPCODE_SYSTEM = 7'b111_0011;

    // System-call selectors. The selector lands in imm[2:0] of the I-type
    // word; funct3 itself stays 000 for both ECALL and EBREAK.
    localparam logic [2:0] FUNCT3_ECALL  = 3'b000;
    localparam logic [2:0] FUNCT3_EBREAK = 3'b001;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_t;

    // {imm[11:0], rs1, funct3, rd, opcode} with rs1 = rd = x0.
    function automatic instr_t get_encoding_syscall_instr(input logic [2:0] sel);
        return {9'b0_0000_0000, sel, 5'b0_0000, 3'b000, 5'b0_0000, OPCODE_SYSTEM};
    endfunction

    localparam instr_t INSTR_EBREAK = get_encoding_syscall_instr(FUNCT3_EBREAK);

endpackage : qu_pkg

// File: rtl/qu_fetch_fifo.sv
// -----------------------------------------------------------------------------
// qu_fetch_fifo -- small circular buffer holding fetched instructions.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties buffer)
//   push, wdata   : write request and data (ignored when full and not popping)
//   pop           : remove head (ignored when empty)
//   flush         : empty the buffer; overrides push and pop
//   rdata         : head entry (valid while empty=0)
//   count         : number of stored entries
//   full, empty   : status flags
// -----------------------------------------------------------------------------
module qu_fetch_fifo
    import qu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = QU_FETCH_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty = (count_q == {CNT_W{1'b0}});
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        // A full buffer may accept a write when the head leaves in the same cycle.
        push_ok_s = push & (~full | pop_ok_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers: pointers and occupancy, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are meaningless while empty so no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : qu_fetch_fifo

// File: rtl/qu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// qu_fetch_ctrl -- instruction fetch controller.
//
// Issues sequential word reads to instruction memory (fixed one-cycle read
// latency), buffers responses with their addresses, and presents them to
// decode with a valid/ready handshake. Redirects flush the buffer and drop the
// outstanding response; a fetched EBREAK halts fetching until the next
// redirect.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req, imem_addr      : read strobe and byte address
//   imem_rdata               : read data, one cycle after imem_req
//   redirect_valid/_pc       : redirect request and target (low 2 bits ignored)
//   instr_valid/_ready       : decode handshake
//   instr, instr_pc          : head instruction and its byte address
//   halted                   : FSM is in HALT
// -----------------------------------------------------------------------------
module qu_fetch_ctrl
    import qu_pkg::*;
#(
    parameter int                   PC_WIDTH = QU_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = QU_PC_RESET_VAL,
    parameter int                   DEPTH    = QU_FETCH_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output instr_t              instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                halted
);

    localparam int                  CNT_W    = $clog2(DEPTH + 1);
    localparam int                  ENTRY_W  = PC_WIDTH + 32;
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] PC_ALIGN = ~PC_WIDTH'(3);

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    // inflight_q: a live (non-stale) response arrives this cycle.
    logic                  inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;

    logic                  imem_req_s;
    logic                  flush_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  pop_eff_s;
    logic                  ebreak_push_s;
    logic                  room_s;
    logic [CNT_W:0]        occupancy_s;
    logic [ENTRY_W-1:0]    fifo_rdata_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    qu_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata ({inflight_pc_q, imem_rdata}),
        .pop   (pop_s),
        .flush (flush_s),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // A redirect discards the arriving response as well as the buffer.
    assign push_s        = inflight_q & ~redirect_valid;
    assign pop_s         = instr_valid & instr_ready;
    assign pop_eff_s     = pop_s & ~fifo_empty_s;
    assign ebreak_push_s = push_s & (imem_rdata == INSTR_EBREAK);

    // Occupancy after this cycle's push/pop; a new request is only issued
    // when its response is guaranteed a free slot next cycle.
    assign occupancy_s = {1'b0, fifo_count_s}
                       + {{CNT_W{1'b0}}, push_s}
                       - {{CNT_W{1'b0}}, pop_eff_s};
    assign room_s      = (occupancy_s < (CNT_W + 1)'(DEPTH))
                       & ~(fifo_full_s & ~pop_eff_s);

    assign imem_req    = imem_req_s;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = ~fifo_empty_s;
    assign instr       = fifo_rdata_s[31:0];
    assign instr_pc    = fifo_rdata_s[32 +: PC_WIDTH];
    assign halted      = (state_q == HALT);

    // FSM next state, request issue, PC advance and stale tracking.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        imem_req_s    = 1'b0;
        flush_s       = 1'b0;
        if (redirect_valid) begin
            flush_s    = 1'b1;
            fetch_pc_d = redirect_pc & PC_ALIGN;
            state_d    = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (room_s) begin
                        imem_req_s    = 1'b1;
                        inflight_d    = 1'b1;
                        inflight_pc_d = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + PC_STEP;
                    end else begin
                        imem_req_s    = 1'b0;
                    end
                    // The request issued alongside an EBREAK push is marked stale.
                    if (ebreak_push_s) begin
                        state_d    = HALT;
                        inflight_d = 1'b0;
                    end else begin
                        state_d    = RUN;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State registers; reset overrides redirect and handshake inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {PC_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule : qu_fetch_ctrl
